seg7_scan_driver: RTL and testbench

// Consumes the 20-bit character bus (4 x 5-bit char codes) and 4-bit decimal-point bus produced by the

---
 rtl/seg7_scan_driver.sv | 132 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Latches a full frame of character codes at frame start, blanks between digits and PWM-dims the on-window.
module seg7_scan_driver #(
    parameter int SLOT_CYCLES  = 100_000,
    parameter int BLANK_CYCLES = 1_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [19:0] seg_data,
    input  logic [3:0]  dp_data,
    input  logic [2:0]  brightness,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam int CW = $clog2(SLOT_CYCLES);
    localparam int WW = CW + 4;
    localparam logic [CW-1:0] TICK_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [WW-1:0] BLANK_W   = WW'(BLANK_CYCLES);
    localparam logic [WW-1:0] ACTIVE_W  = WW'(SLOT_CYCLES - BLANK_CYCLES);

    logic [CW-1:0] tick_cnt_reg;
    logic [1:0]    digit_idx_reg;
    logic [19:0]   shadow_seg_reg;
    logic [3:0]    shadow_dp_reg;
    logic [3:0]    an_reg;
    logic [6:0]    seg_reg;
    logic          dp_reg;
    logic          frame_start_reg;

    logic [3:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;
    logic          frame_edge;
    logic          lit;
    logic [WW-1:0] on_len;
    logic [WW-1:0] tick_w;
    logic [4:0]    shadow_char [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_char
            assign shadow_char[gi] = shadow_seg_reg[gi*5 +: 5];
        end
    endgenerate

    function automatic logic [6:0] decode(input logic [4:0] code);
        logic [6:0] p;
        case (code)
            5'd0:    p = 7'b1000000;
            5'd1:    p = 7'b1111001;
            5'd2:    p = 7'b0100100;
            5'd3:    p = 7'b0110000;
            5'd4:    p = 7'b0011001;
            5'd5:    p = 7'b0010010;
            5'd6:    p = 7'b0000010;
            5'd7:    p = 7'b1111000;
            5'd8:    p = 7'b0000000;
            5'd9:    p = 7'b0010000;
            5'd10:   p = 7'b0111111;
            5'd11:   p = 7'b0000110;
            5'd12:   p = 7'b0101111;
            5'd13:   p = 7'b1000111;
            5'd14:   p = 7'b0001000;
            5'd15:   p = 7'b0001110;
            5'd16:   p = 7'b0001001;
            5'd17:   p = 7'b0100011;
            5'd18:   p = 7'b0000011;
            5'd19:   p = 7'b0100001;
            5'd20:   p = 7'b0101011;
            5'd21:   p = 7'b1100011;
            5'd22:   p = 7'b0000111;
            5'd23:   p = 7'b1000110;
            default: p = 7'b1111111;
        endcase
        return p;
    endfunction

    assign frame_edge = (digit_idx_reg == 2'd0) && (tick_cnt_reg == '0);

    // Brightness is applied live; the window width is (level+1)/8 of the non-blank part of the slot.
    always_comb begin
        on_len   = ((WW'(brightness) + WW'(1)) * ACTIVE_W) >> 3;
        tick_w   = WW'(tick_cnt_reg);
        lit      = enable && (tick_w >= BLANK_W) && (tick_w < BLANK_W + on_len);
        an_next  = 4'b1111;
        seg_next = 7'b1111111;
        dp_next  = 1'b1;
        if (lit) begin
            an_next  = ~(4'b0001 << digit_idx_reg);
            seg_next = decode(shadow_char[digit_idx_reg]);
            dp_next  = ~shadow_dp_reg[digit_idx_reg];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_reg    <= '0;
            digit_idx_reg   <= 2'd0;
            shadow_seg_reg  <= {20{1'b1}};
            shadow_dp_reg   <= 4'b0000;
            an_reg          <= 4'b1111;
            seg_reg         <= 7'b1111111;
            dp_reg          <= 1'b1;
            frame_start_reg <= 1'b0;
        end else begin
            if (tick_cnt_reg == TICK_LAST) begin
                tick_cnt_reg  <= '0;
                digit_idx_reg <= digit_idx_reg + 2'd1;
            end else begin
                tick_cnt_reg  <= tick_cnt_reg + CW'(1);
            end
            if (frame_edge) begin
                shadow_seg_reg <= seg_data;
                shadow_dp_reg  <= dp_data;
            end
            frame_start_reg <= frame_edge;
            an_reg          <= an_next;
            seg_reg         <= seg_next;
            dp_reg          <= dp_next;
        end
    end

    assign an          = an_reg;
    assign seg         = seg_reg;
    assign dp          = dp_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios plus randomized frames against a cycle-position model.
module tb_seg7_scan_driver;
    localparam int SLOT  = 16;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [19:0] seg_data = '0;
    logic [3:0]  dp_data = '0;
    logic [2:0]  brightness = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    seg7_scan_driver #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
        .clk(clk), .reset(reset), .enable(enable), .seg_data(seg_data), .dp_data(dp_data),
        .brightness(brightness), .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    int         edge_n = 0;
    int         m_chars [4];
    logic [3:0] m_dp;
    string      lit_tbl [32];

    // Glyphs described as the set of lit segment letters; unlisted segments stay dark.
    function automatic logic [6:0] glyph(input int code);
        logic [6:0] p;
        string s;
        p = 7'b1111111;
        s = lit_tbl[code];
        for (int i = 0; i < s.len(); i++) p[int'(s[i]) - 97] = 1'b0;
        return p;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h edge=%0d", tag, obs, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        edge_n = 0;
        for (int k = 0; k < 4; k++) m_chars[k] = 31;
        m_dp = 4'b0000;
    endtask

    task automatic step();
        int         e, slot, t, w;
        bit         on;
        logic       en_s;
        logic [2:0] br;
        logic [19:0] sd;
        logic [3:0] dd;
        logic [3:0] x_an;
        logic [6:0] x_seg;
        logic       x_dp;
        e = edge_n; en_s = enable; br = brightness; sd = seg_data; dd = dp_data;
        @(posedge clk);
        if (e % FRAME == 0) begin
            for (int k = 0; k < 4; k++) m_chars[k] = int'(sd[k*5 +: 5]);
            m_dp = dd;
        end
        slot = (e / SLOT) % 4;
        t    = e % SLOT;
        w    = ((int'(br) + 1) * (SLOT - BLANK)) / 8;
        on   = en_s && (t >= BLANK) && (t < BLANK + w);
        x_an  = on ? ~(4'b0001 << slot) : 4'b1111;
        x_seg = on ? glyph(m_chars[slot]) : 7'b1111111;
        x_dp  = on ? ~m_dp[slot] : 1'b1;
        #1;
        check("an", {4'b0, an}, {4'b0, x_an});
        check("seg", {1'b0, seg}, {1'b0, x_seg});
        check("dp", {7'b0, dp}, {7'b0, x_dp});
        check("frame_start", {7'b0, frame_start}, {7'b0, (e % FRAME == 0)});
        if (e % FRAME == FRAME - 1)
            $display("frame %0d done: chars=%0d,%0d,%0d,%0d dp=%b checks=%0d",
                     e / FRAME, m_chars[3], m_chars[2], m_chars[1], m_chars[0], m_dp, checks);
        edge_n++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(input int pos);
        for (int i = 0; i < FRAME && (edge_n % FRAME) != pos; i++) step();
    endtask

    initial begin
        lit_tbl[0] = "abcdef";  lit_tbl[1] = "bc";     lit_tbl[2] = "abdeg";  lit_tbl[3] = "abcdg";
        lit_tbl[4] = "bcfg";    lit_tbl[5] = "acdfg";  lit_tbl[6] = "acdefg"; lit_tbl[7] = "abc";
        lit_tbl[8] = "abcdefg"; lit_tbl[9] = "abcdfg"; lit_tbl[10] = "g";     lit_tbl[11] = "adefg";
        lit_tbl[12] = "eg";     lit_tbl[13] = "def";   lit_tbl[14] = "abcefg"; lit_tbl[15] = "aefg";
        lit_tbl[16] = "bcefg";  lit_tbl[17] = "cdeg";  lit_tbl[18] = "cdefg"; lit_tbl[19] = "bcdeg";
        lit_tbl[20] = "ceg";    lit_tbl[21] = "cde";   lit_tbl[22] = "defg";  lit_tbl[23] = "adef";
        for (int k = 24; k < 32; k++) lit_tbl[k] = "";

        // Reset state
        #12;
        check("rst_an", {4'b0, an}, 8'h0f);
        check("rst_seg", {1'b0, seg}, 8'h7f);
        check("rst_dp", {7'b0, dp}, 8'h01);
        check("rst_fs", {7'b0, frame_start}, 8'h00);

        // Basic scan of 1,2,3,4 at full brightness
        seg_data = {5'd1, 5'd2, 5'd3, 5'd4};
        dp_data = 4'b0000;
        brightness = 3'd7;
        enable = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        run(3);
        check("t1_an_digit0", {4'b0, an}, 8'h0e);
        check("t1_seg_4", {1'b0, seg}, {1'b0, 7'b0011001});
        run(FRAME - 3);

        // Brightness 3 then 0
        brightness = 3'd3;
        run(FRAME);
        brightness = 3'd0;
        run(FRAME);

        // Mid-frame data change stays invisible until the next frame
        brightness = 3'd7;
        run_to(SLOT + 3);
        seg_data = {4{5'd8}};
        run_to(SLOT + 5);
        check("t3_old_char", {1'b0, seg}, {1'b0, 7'b0110000});
        run_to(0);
        run(FRAME);

        // o/9 pattern with one decimal point
        seg_data = {5'd9, 5'd17, 5'd9, 5'd17};
        dp_data = 4'b0100;
        run_to(0);
        run(4);
        check("t4_seg_o", {1'b0, seg}, {1'b0, 7'b0100011});
        run(FRAME - 4);

        // Display disabled for a full frame, then resumed
        enable = 1'b0;
        run(FRAME);
        enable = 1'b1;
        run(FRAME);

        // Randomized frames with mid-frame disturbances
        for (int f = 0; f < 20; f++) begin
            seg_data = 20'($urandom);
            dp_data = 4'($urandom);
            brightness = 3'($urandom);
            for (int c = 0; c < FRAME; c++) begin
                if ($urandom_range(7) == 0) brightness = 3'($urandom);
                if ($urandom_range(15) == 0) enable = ~enable;
                if ($urandom_range(7) == 0) seg_data = 20'($urandom);
                if ($urandom_range(7) == 0) dp_data = 4'($urandom);
                step();
            end
        end

        // Asynchronous reset in the middle of digit2's on-window
        enable = 1'b1;
        brightness = 3'd7;
        run_to(2 * SLOT + 6);
        check("t6_an_digit2", {4'b0, an}, 8'h0b);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_an", {4'b0, an}, 8'h0f);
        check("t6_async_seg", {1'b0, seg}, 8'h7f);
        check("t6_async_dp", {7'b0, dp}, 8'h01);
        seg_data = 20'($urandom);
        dp_data = 4'($urandom);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        run(FRAME + 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
